// File: rtl/joy_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// joy_scan_ctrl
//
// Scans two 8-button joysticks behind a 16-bit 74HC165 shift-register chain.
// A scan loads the chain (joy_load_o low), clocks 16 bits out of it and then
// publishes the two player bytes together with a one-cycle frame strobe.
//
// Parameters
//   DIV    clk_i cycles per half bit period (1..255)
//   NBITS  serial bits per scan (16: 8 for player 1, then 8 for player 2)
//
// Ports
//   clk_i        in   system clock
//   rst_n_i      in   asynchronous active-low reset
//   auto_i       in   1 = rescan continuously
//   start_i      in   single-scan request (ignored while a scan runs)
//   joy_data_i   in   serial data from the chain
//   joy_clk_o    out  shift clock to the chain
//   joy_load_o   out  parallel load to the chain, active-low
//   joy1_o       out  player 1 {start,fire3,fire2,fire1,right,left,down,up}, active-low
//   joy2_o       out  player 2, same layout
//   frame_vld_o  out  one-cycle strobe when a scan completes
//   busy_o       out  high while loading or shifting
//   frame_cnt_o  out  completed scans, modulo 256
//
// Build option
//   JOY_SCAN_DEBOUNCE_EN  when defined, joy1_o/joy2_o only change once two
//                         consecutive raw frames agree.
// -----------------------------------------------------------------------------
module joy_scan_ctrl #(
    parameter int unsigned DIV   = 8,
    parameter int unsigned NBITS = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       auto_i,
    input  logic       start_i,
    input  logic       joy_data_i,
    output logic       joy_clk_o,
    output logic       joy_load_o,
    output logic [7:0] joy1_o,
    output logic [7:0] joy2_o,
    output logic       frame_vld_o,
    output logic       busy_o,
    output logic [7:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // One bit period (and the whole LOAD phase) is 2*DIV cycles; the chain
    // clock is low for the first DIV of them and high for the rest.
    localparam logic [8:0] C_PERIOD_LAST = 9'(2 * DIV - 1);
    localparam logic [8:0] C_HALF        = 9'(DIV);
    localparam logic [8:0] C_SAMPLE      = 9'(DIV - 1);
    localparam logic [3:0] C_LAST_BIT    = 4'(NBITS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [8:0]  r_div_cnt;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_shift;
    logic        w_period_end;
    logic        w_sample;
    logic        w_active;

`ifdef JOY_SCAN_DEBOUNCE_EN
    logic [15:0] r_prev;
`endif

    assign w_active     = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
    assign w_period_end = (r_div_cnt == C_PERIOD_LAST);
    // Data is taken on the last low cycle, while the chain output is still
    // settled from the previous rising edge.
    assign w_sample     = (r_state == ST_SHIFT) && (r_div_cnt == C_SAMPLE);

    // NOTE: every state register is assigned with <= so all flops update
    // together on the edge regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        joy_load_o  = 1'b1;
        joy_clk_o   = 1'b0;
        busy_o      = 1'b0;
        frame_vld_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // start_i and auto_i together are still a single request.
                if (start_i || auto_i) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                joy_load_o = 1'b0;
                busy_o     = 1'b1;
                if (w_period_end) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_o    = 1'b1;
                joy_clk_o = (r_div_cnt >= C_HALF);
                if (w_period_end && (r_bit_cnt == C_LAST_BIT)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_vld_o = 1'b1;
                w_state_nxt = auto_i ? ST_LOAD : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Divider and bit counters. The divider restarts on every state entry and
    // at every bit-period boundary, so bit periods cannot drift.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (!w_active || (w_state_nxt != r_state) || w_period_end) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 9'd1;
            end

            if (r_state != ST_SHIFT) begin
                r_bit_cnt <= '0;
            end else if (w_period_end) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    // Shift buffer and published outputs. Bits enter at the LSB, so the first
    // bit received ends up in r_shift[15], i.e. joy1_o[7].
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shift     <= 16'hFFFF;
            joy1_o      <= 8'hFF;
            joy2_o      <= 8'hFF;
            frame_cnt_o <= 8'h00;
`ifdef JOY_SCAN_DEBOUNCE_EN
            r_prev      <= 16'hFFFF;
`endif
        end else begin
            if (w_sample) begin
                r_shift <= {r_shift[14:0], joy_data_i};
            end

            if (r_state == ST_DONE) begin
                frame_cnt_o <= frame_cnt_o + 8'd1;
`ifdef JOY_SCAN_DEBOUNCE_EN
                // Publish only a frame that matches the previous raw frame.
                if (r_shift == r_prev) begin
                    {joy1_o, joy2_o} <= r_shift;
                end
                r_prev <= r_shift;
`else
                {joy1_o, joy2_o} <= r_shift;
`endif
            end
        end
    end

endmodule

// File: tb/tb_joy_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for joy_scan_ctrl with DIV=2. A behavioural 74HC165 chain feeds the
// DUT; expected player bytes are pushed to a queue when each scan is started
// and compared one cycle after the matching frame strobe.
module tb_joy_scan_ctrl;

    localparam int DIV         = 2;
    localparam int SCAN_CYCLES = 34 * DIV + 1;   // request cycle -> strobe cycle

`ifdef JOY_SCAN_DEBOUNCE_EN
    localparam logic [15:0] DEB_EXP [3] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};
`else
    localparam logic [15:0] DEB_EXP [3] = '{16'h0000, 16'h7FFF, 16'h7FFF};
`endif
    localparam logic [15:0] DEB_PAT [3] = '{16'h0000, 16'hFFFE, 16'hFFFE};

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       auto_i;
    logic       start_i;
    logic       joy_data_i;
    logic       joy_clk_o;
    logic       joy_load_o;
    logic [7:0] joy1_o;
    logic [7:0] joy2_o;
    logic       frame_vld_o;
    logic       busy_o;
    logic [7:0] frame_cnt_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vld_count = 0;
    bit cmp_pending = 1'b0;

    logic [15:0] exp_q [$];
    logic [15:0] sb_exp;
    logic [15:0] m_shown = 16'hFFFF;
`ifdef JOY_SCAN_DEBOUNCE_EN
    logic [15:0] m_prev = 16'hFFFF;
`endif

    // Chain model: parallel load while joy_load_o is low, advance on each
    // rising joy_clk_o, serial output is the current bit (bit0 first).
    logic [15:0] chain_pat     = 16'hFFFF;
    logic [15:0] chain_latched = 16'hFFFF;
    int          chain_idx     = 0;

    int w_at, w_nload, w_nrise, w_nbusy;
    int t0, a_prev, vc_before;

    joy_scan_ctrl #(
        .DIV   (DIV),
        .NBITS (16)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .auto_i      (auto_i),
        .start_i     (start_i),
        .joy_data_i  (joy_data_i),
        .joy_clk_o   (joy_clk_o),
        .joy_load_o  (joy_load_o),
        .joy1_o      (joy1_o),
        .joy2_o      (joy2_o),
        .frame_vld_o (frame_vld_o),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge joy_load_o or posedge joy_clk_o) begin
        if (!joy_load_o) begin
            chain_latched = chain_pat;
            chain_idx     = 0;
        end else if (chain_idx < 16) begin
            chain_idx++;
        end
    end
    assign joy_data_i = (chain_idx < 16) ? chain_latched[chain_idx] : 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Arrival order to output bits: bit k lands in output bit 15-k of {joy1,joy2}.
    function automatic logic [15:0] map_frame(input logic [15:0] p);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[15-k] = p[k];
        return r;
    endfunction

    task automatic push_scan(input logic [15:0] p);
        logic [15:0] raw;
        raw = map_frame(p);
`ifdef JOY_SCAN_DEBOUNCE_EN
        if (raw == m_prev) m_shown = raw;
        m_prev = raw;
`else
        m_shown = raw;
`endif
        exp_q.push_back(m_shown);
    endtask

    task automatic model_reset();
        m_shown = 16'hFFFF;
`ifdef JOY_SCAN_DEBOUNCE_EN
        m_prev = 16'hFFFF;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for frame_vld_o, counting load-low cycles, chain clock
    // rises and busy cycles on the way. Drops start_i after the first cycle.
    task automatic wait_vld(input int budget, output int at, output int n_load,
                            output int n_rise, output int n_busy);
        logic prev_clk;
        at = -1; n_load = 0; n_rise = 0; n_busy = 0;
        prev_clk = joy_clk_o;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (!joy_load_o) n_load++;
            if (joy_clk_o && !prev_clk) n_rise++;
            prev_clk = joy_clk_o;
            if (busy_o) n_busy++;
            if (frame_vld_o) begin
                at = cyc;
                break;
            end
        end
        check("vld_seen", frame_vld_o, 1'b1);
    endtask

    // Scoreboard: compare published bytes one cycle after each strobe.
    always @(negedge clk) begin
        if (cmp_pending) begin
            cmp_pending = 1'b0;
            check("sb_frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                check("sb_joy1", joy1_o, sb_exp[15:8]);
                check("sb_joy2", joy2_o, sb_exp[7:0]);
            end
        end
        if (frame_vld_o) begin
            vld_count++;
            cmp_pending = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0;
        auto_i  = 1'b0;
        start_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_load", joy_load_o, 1'b1);
        check("rst_clk", joy_clk_o, 1'b0);
        check("rst_joy1", joy1_o, 8'hFF);
        check("rst_joy2", joy2_o, 8'hFF);
        check("rst_vld", frame_vld_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_cnt", frame_cnt_o, 8'h00);
        rst_n_i = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_request_busy", busy_o, 1'b0);
        check("idle_no_request_load", joy_load_o, 1'b1);

        // Single scan of 16'hA55A
        chain_pat = 16'hA55A;
        push_scan(chain_pat);
        start_i = 1'b1;
        t0 = cyc;
        wait_vld(SCAN_CYCLES + 20, w_at, w_nload, w_nrise, w_nbusy);
        check("t1_vld_cycle", w_at - t0, SCAN_CYCLES);
        check("t1_load_cycles", w_nload, 2 * DIV);
        check("t1_clk_pulses", w_nrise, 16);
        check("t1_busy_cycles", w_nbusy, 34 * DIV);
        @(negedge clk);
        check("t1_joy1", joy1_o, 8'h5A);
        check("t1_joy2", joy2_o, 8'hA5);
        check("t1_cnt", frame_cnt_o, 8'd1);
        check("t1_busy_after", busy_o, 1'b0);
        check("t1_vld_single_cycle", frame_vld_o, 1'b0);

        // start_i during SHIFT is ignored
        vc_before = vld_count;
        chain_pat = 16'h1234;
        push_scan(chain_pat);
        start_i = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        check("t2_in_shift", busy_o & joy_load_o, 1'b1);
        start_i = 1'b1;
        wait_vld(SCAN_CYCLES + 20, w_at, w_nload, w_nrise, w_nbusy);
        check("t2_vld_cycle", w_at - t0, SCAN_CYCLES);
        repeat (150) @(negedge clk);
        check("t2_single_frame", vld_count - vc_before, 1);
        check("t2_idle_busy", busy_o, 1'b0);
        check("t2_cnt", frame_cnt_o, 8'd2);

        // Reset in the high half of bit 7
        vc_before = vld_count;
        chain_pat = 16'h0F0F;
        start_i = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
        repeat (34) @(negedge clk);
        check("t3_pre_clk_high", joy_clk_o, 1'b1);
        check("t3_pre_busy", busy_o, 1'b1);
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check("t3_rst_load", joy_load_o, 1'b1);
        check("t3_rst_clk", joy_clk_o, 1'b0);
        check("t3_rst_joy1", joy1_o, 8'hFF);
        check("t3_rst_joy2", joy2_o, 8'hFF);
        check("t3_rst_cnt", frame_cnt_o, 8'h00);
        check("t3_rst_busy", busy_o, 1'b0);
        check("t3_rst_vld", frame_vld_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        repeat (120) @(negedge clk);
        check("t3_no_frame", vld_count - vc_before, 0);
        check("t3_idle_busy", busy_o, 1'b0);
        check("t3_idle_cnt", frame_cnt_o, 8'h00);

        // Free-run: three gap-less scans, then auto_i dropped mid-scan 4
        chain_pat = 16'hC3F0;
        for (int i = 0; i < 4; i++) push_scan(chain_pat);
        auto_i = 1'b1;
        t0 = cyc;
        wait_vld(SCAN_CYCLES + 20, w_at, w_nload, w_nrise, w_nbusy);
        check("t4_vld1_cycle", w_at - t0, SCAN_CYCLES);
        for (int s = 2; s <= 3; s++) begin
            a_prev = w_at;
            @(negedge clk);
            check("t4_gapless_load", joy_load_o, 1'b0);
            wait_vld(SCAN_CYCLES + 20, w_at, w_nload, w_nrise, w_nbusy);
            check("t4_vld_spacing", w_at - a_prev, SCAN_CYCLES);
        end
        a_prev = w_at;
        @(negedge clk);
        check("t4_gapless_load", joy_load_o, 1'b0);
        check("t4_cnt3", frame_cnt_o, 8'd3);
        repeat (30) @(negedge clk);
        auto_i = 1'b0;
        wait_vld(SCAN_CYCLES + 20, w_at, w_nload, w_nrise, w_nbusy);
        check("t4_vld4_spacing", w_at - a_prev, SCAN_CYCLES);
        @(negedge clk);
        check("t4_end_busy", busy_o, 1'b0);
        check("t4_end_load", joy_load_o, 1'b1);
        check("t4_cnt4", frame_cnt_o, 8'd4);
        repeat (100) @(negedge clk);
        check("t4_stays_idle", busy_o, 1'b0);

        // 256 scans wrap the frame counter
        do_reset();
        vc_before = vld_count;
        chain_pat = 16'h8001;
        for (int i = 0; i < 256; i++) push_scan(chain_pat);
        auto_i = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            wait_vld(SCAN_CYCLES + 20, w_at, w_nload, w_nrise, w_nbusy);
            if (i == 256) auto_i = 1'b0;
            @(negedge clk);
            if (i == 255) check("t5_cnt_255", frame_cnt_o, 8'd255);
        end
        check("t5_cnt_wrapped", frame_cnt_o, 8'h00);
        check("t5_busy", busy_o, 1'b0);
        check("t5_frames", vld_count - vc_before, 256);

        // Frames 0000, FFFE, FFFE (debounce behaviour depends on build)
        do_reset();
        for (int s = 0; s < 3; s++) begin
            chain_pat = DEB_PAT[s];
            push_scan(chain_pat);
            start_i = 1'b1;
            wait_vld(SCAN_CYCLES + 20, w_at, w_nload, w_nrise, w_nbusy);
            @(negedge clk);
            check("t6_outputs", {joy1_o, joy2_o}, DEB_EXP[s]);
            check("t6_cnt", frame_cnt_o, 8'(s + 1));
            repeat (3) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
